// File: rtl/crossbar_tdm_scheduler.sv
// TDM crossbar scheduler: one buffered word per input, released when the
// rotating phase lines the input up with the word's destination output.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  phase-advance enable
//   in_valid/in_data/   per-input word offer, packed by input index j
//   in_dest/in_ready
//   bus_o, shift_o      buffered words and phase, feeding the rotator
//   out_valid           per-output delivery flag (after rotation)
//   out_ready           per-output downstream accept
//   err_dest            sticky flag, a word named a nonexistent output
module crossbar_tdm_scheduler #(
  parameter int N       = 8,
  parameter int W       = 8,
  parameter int SHIFT_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N-1:0]           in_valid,
  input  logic [N*W-1:0]         in_data,
  input  logic [N*SHIFT_W-1:0]   in_dest,
  output logic [N-1:0]           in_ready,
  output logic [N*W-1:0]         bus_o,
  output logic [SHIFT_W-1:0]     shift_o,
  output logic [N-1:0]           out_valid,
  input  logic [N-1:0]           out_ready,
  output logic                   err_dest
);

  // One extra bit so N itself and j+N-P never overflow.
  localparam int            CW = SHIFT_W + 1;
  localparam logic [CW-1:0] NC = CW'(N);

  logic [SHIFT_W-1:0]          r_p;
  logic [N-1:0][W-1:0]         r_data;
  logic [N-1:0][SHIFT_W-1:0]   r_dest;
  logic [N-1:0]                r_v;
  logic                        r_err;

  logic [N-1:0] w_match;
  logic [N-1:0] w_deliver;
  logic [N-1:0] w_ovalid;
  logic [N-1:0] w_ready;

  // (a - b) mod N for a, b in 0..N-1
  function automatic logic [CW-1:0] sub_mod(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b
  );
    if (a >= b) sub_mod = a - b;
    else        sub_mod = a + NC - b;
  endfunction

  always_comb begin
    w_match   = '0;
    w_deliver = '0;
    w_ovalid  = '0;
    for (int j = 0; j < N; j++) begin
      w_match[j] = r_v[j] &&
        ({1'b0, r_dest[j]} == sub_mod(CW'(j), {1'b0, r_p}));
      // A matched entry lands on output dest, so the
      // rotated view and the accept both key off dest.
      for (int k = 0; k < N; k++) begin
        if (r_dest[j] == SHIFT_W'(k)) begin
          w_ovalid[k]  = w_ovalid[k] | w_match[j];
          w_deliver[j] = w_deliver[j] |
                         (w_match[j] & out_ready[k]);
        end
      end
    end
  end

  assign w_ready = ~r_v | w_deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_v    <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
      r_dest <= '0;
    end else begin
      if (en) begin
        if (r_p == SHIFT_W'(N-1)) r_p <= '0;
        else                      r_p <= r_p + 1'b1;
      end
      for (int j = 0; j < N; j++) begin
        if (in_valid[j] && w_ready[j]) begin
          r_data[j] <= in_data[j*W +: W];
          r_dest[j] <= in_dest[j*SHIFT_W +: SHIFT_W];
          // Bad destinations are dropped, not buffered.
          if ({1'b0, in_dest[j*SHIFT_W +: SHIFT_W]} < NC) begin
            r_v[j] <= 1'b1;
          end else begin
            r_v[j] <= 1'b0;
            r_err  <= 1'b1;
          end
        end else if (w_deliver[j]) begin
          r_v[j] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign bus_o     = r_data;
  assign shift_o   = r_p;
  assign out_valid = w_ovalid;
  assign err_dest  = r_err;

endmodule

// File: tb/tb_crossbar_tdm_scheduler.sv
// Bench for crossbar_tdm_scheduler: directed cases plus random traffic
// against a per-input buffer model, and an N=5 instance for mod-N/errors.
module tb_crossbar_tdm_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N*SW-1:0] in_dest;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  bus_o;
  logic [SW-1:0]   shift_o;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic            err_dest;

  logic            en5;
  logic [4:0]      in_valid5;
  logic [39:0]     in_data5;
  logic [14:0]     in_dest5;
  logic [4:0]      in_ready5;
  logic [39:0]     bus5;
  logic [2:0]      shift5;
  logic [4:0]      out_valid5;
  logic [4:0]      out_ready5;
  logic            err5;

  crossbar_tdm_scheduler #(.N(N), .W(W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_ready (in_ready),
    .bus_o    (bus_o),
    .shift_o  (shift_o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_dest (err_dest)
  );

  crossbar_tdm_scheduler #(.N(5), .W(8)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en5),
    .in_valid (in_valid5),
    .in_data  (in_data5),
    .in_dest  (in_dest5),
    .in_ready (in_ready5),
    .bus_o    (bus5),
    .shift_o  (shift5),
    .out_valid(out_valid5),
    .out_ready(out_ready5),
    .err_dest (err5)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int         mp;
  bit         mv   [N];
  int         mdst [N];
  logic [7:0] mdat [N];
  bit         merr;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mp   = 0;
    merr = 0;
    for (int j = 0; j < N; j++) mv[j] = 0;
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic step();
    logic [N-1:0] eov;
    logic [N-1:0] eir;
    bit           del [N];
    #1;
    eov = '0;
    for (int j = 0; j < N; j++) begin
      del[j] = mv[j] && (mdst[j] == ((j - mp + N) % N))
               && out_ready[mdst[j]];
      eir[j] = !mv[j] || del[j];
      if (mv[j] && mdst[j] == ((j - mp + N) % N))
        eov[mdst[j]] = 1'b1;
    end
    chk("shift", shift_o, mp);
    chk("out_valid", out_valid, eov);
    chk("in_ready", in_ready, eir);
    chk("err_dest", err_dest, merr);
    for (int j = 0; j < N; j++)
      if (mv[j]) chk("bus_word", bus_o[j*W +: W], mdat[j]);
    @(posedge clk);
    for (int j = 0; j < N; j++) begin
      if (in_valid[j] && eir[j]) begin
        mv[j]   = 1;
        mdst[j] = int'(in_dest[j*SW +: SW]);
        mdat[j] = in_data[j*W +: W];
      end else if (del[j]) begin
        mv[j] = 0;
      end
    end
    if (en) mp = (mp + 1) % N;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 1'b0;
    in_valid = '0;
    in_data = '0;
    in_dest = '0;
    out_ready = '1;
    en5 = 1'b0;
    in_valid5 = '0;
    in_data5 = '0;
    in_dest5 = '0;
    out_ready5 = '1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_shift", shift_o, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_iready", in_ready, 4'hF);
    chk("rst_err", err_dest, 0);
    rst_n = 1'b1;
    step();

    // Input 1 -> dest 3 offered at P=0
    en = 1'b1;
    in_valid = 4'b0010;
    in_data[15:8] = 8'hA5;
    in_dest[3:2] = 2'd3;
    step();
    in_valid = '0;
    step();
    #1;
    chk("ex1_ovalid", out_valid, 4'b1000);
    chk("ex1_rot_word3", bus_o[15:8], 8'hA5);
    step();

    // Full permutation matching P=1
    for (int i = 0; i < N && mp != 0; i++) step();
    in_valid = 4'hF;
    in_data = 32'h44332211;
    in_dest = {2'd2, 2'd1, 2'd0, 2'd3};
    step();
    in_valid = '0;
    #1;
    chk("ex2_ovalid", out_valid, 4'hF);
    chk("ex2_iready", in_ready, 4'hF);
    step();

    // Output 2 stalled for 6 cycles
    in_valid = 4'b0001;
    in_data[7:0] = 8'h5A;
    in_dest[1:0] = 2'd2;
    out_ready = 4'b1011;
    step();
    in_valid = '0;
    repeat (5) step();
    out_ready = 4'hF;
    repeat (5) step();
    chk("ex3_drained", in_ready, 4'hF);

    // Phase frozen at 3
    for (int i = 0; i < N && mp != 3; i++) step();
    en = 1'b0;
    in_valid = 4'b0011;
    in_dest = {2'd0, 2'd0, 2'd0, 2'd1};
    step();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ex4_shift_hold", shift_o, 2'd3);
    end

    // Reset with entries full at P=2
    en = 1'b1;
    out_ready = '0;
    for (int i = 0; i < N && mp != 1; i++) step();
    in_valid = 4'hF;
    in_dest = 8'hE4;
    step();
    chk("ex5_p2", shift_o, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("ex5_rst_shift", shift_o, 0);
    chk("ex5_rst_ovalid", out_valid, 0);
    chk("ex5_rst_iready", in_ready, 4'hF);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = '0;
    out_ready = '1;
    repeat (N + 1) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      in_valid = N'($urandom);
      in_data = $urandom;
      in_dest = N*SW'($urandom);
      for (int k = 0; k < N; k++)
        out_ready[k] = ($urandom_range(0, 3) != 0);
      step();
    end

    // N=5: bad destination and mod-5 rotation
    in_valid = '0;
    en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("n5_rst_err", err5, 0);
    @(posedge clk);
    #1;
    en5 = 1'b1;
    in_valid5 = 5'b00100;
    in_dest5[8:6] = 3'd6;
    #1;
    chk("n5_ir2", in_ready5[2], 1'b1);
    @(posedge clk);
    #1;
    in_valid5 = '0;
    chk("n5_err_set", err5, 1'b1);
    chk("n5_not_buffered", in_ready5, 5'h1F);
    chk("n5_no_ovalid", out_valid5, 0);
    in_valid5 = 5'b10000;
    in_data5[39:32] = 8'h3C;
    in_dest5[14:12] = 3'd1;
    @(posedge clk);
    #1;
    in_valid5 = '0;
    for (int i = 0; i < 6 && shift5 != 3'd3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("n5_p3", shift5, 3'd3);
    chk("n5_ovalid", out_valid5, 5'b00010);
    chk("n5_rot_word1", bus5[39:32], 8'h3C);
    @(posedge clk);
    #1;
    chk("n5_p4", shift5, 3'd4);
    chk("n5_delivered", out_valid5, 0);
    chk("n5_empty", in_ready5, 5'h1F);
    @(posedge clk);
    #1;
    chk("n5_wrap", shift5, 3'd0);
    chk("n5_err_sticky", err5, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("n5_err_clr", err5, 1'b0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_tdm_scheduler.md
CROSSBAR_TDM_SCHEDULER -- requirements
Module: crossbar_tdm_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of crossbar ports (N >= 2).
REQ-002 SHALL have parameter W, default 8, meaning word width in bits.
REQ-003 SHALL have parameter SHIFT_W, default $clog2(N), meaning width of the phase, shift and destination fields.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, phase-advance enable.
REQ-007 SHALL have port in_valid, input, N, per-input-port word offer.
REQ-008 SHALL have port in_data, input, N*W, input words; word j at bits [j*W +: W].
REQ-009 SHALL have port in_dest, input, N*SHIFT_W, destination output port of word j at bits [j*SHIFT_W +: SHIFT_W].
REQ-010 SHALL have port in_ready, output, N, per-input-port accept.
REQ-011 SHALL have port bus_o, output, N*W, buffered words in input-port order; this is the rotating word stage's in_bus.
REQ-012 SHALL have port shift_o, output, SHIFT_W, current phase; this is the rotating word stage's shift.
REQ-013 SHALL have port out_valid, output, N, bit k set when the rotated bus word at output k is a real delivery.
REQ-014 SHALL have port out_ready, input, N, per-output-port accept from downstream.
REQ-015 SHALL have port err_dest, output, 1, sticky flag for an out-of-range destination.

Function
REQ-016 SHALL hold one buffer entry per input j: data, dest and valid bit buf_v[j].
REQ-017 SHALL keep phase register P in 0..N-1; when en=1, P advances by 1 per cycle and wraps N-1 -> 0; when en=0, P holds.
REQ-018 SHALL drive shift_o = P and bus_o[j] = buffer data j, both directly from registers.
REQ-019 SHALL compute match[j] = buf_v[j] AND (buf_dest[j] == (j - P) mod N); output k then receives input (k+P) mod N.
REQ-020 SHALL drive out_valid[k] = match[(k+P) mod N], combinationally from registers.
REQ-021 SHALL treat deliver[j] = match[j] AND out_ready[buf_dest[j]] as the transfer; the entry clears at the next edge unless refilled.
REQ-022 SHALL drive in_ready[j] = NOT buf_v[j] OR deliver[j], permitting back-to-back fill on the delivery cycle.
REQ-023 SHALL capture in_data and in_dest into entry j when in_valid[j] AND in_ready[j]; the word is first visible on bus_o one cycle later.
REQ-024 SHALL, for a word captured with in_dest >= N, set err_dest and leave buf_v[j] clear (word discarded); err_dest clears only on reset.
REQ-025 SHALL bound delivery latency, with en=1 and out_ready all-ones, to at most N cycles from capture.
REQ-026 SHALL not change out_valid, bus_o or shift_o when out_ready is deasserted; a matched but unaccepted word stays buffered until its phase recurs.
REQ-027 SHALL allow all N entries to deliver in the same cycle when their destinations form the permutation that matches P.
REQ-028 SHALL compute all mod-N arithmetic correctly for non-power-of-2 N, with no reliance on SHIFT_W overflow.

Reset
REQ-029 SHALL, while rst_n=0, force P=0, all buf_v=0 and err_dest=0 asynchronously; bus_o contents are don't-care.
REQ-030 SHALL hold shift_o=0, out_valid=0 and in_ready=all-ones during reset; words in flight at reset assertion are discarded.
REQ-031 SHALL accept no word on the first rising edge at which rst_n is already high if rst_n rose within setup of that edge; a bench drives in_valid=0 for one cycle after release.

Verification (N=4, W=8)
REQ-032 SHALL pass this case: input 1 offers 0xA5 to dest 3 while P=0 -> captured, buffered at P=1, out_valid=4'b1000 at P=2, and the shifter output word 3 = 0xA5.
REQ-033 SHALL pass this case: all inputs j offer dest (j-1) mod 4 at P=0 -> every entry matches at P=1, out_valid=4'b1111, and all in_ready=1 that cycle.
REQ-034 SHALL pass this case: input 0 targets dest 2 with out_ready[2]=0 for 6 cycles -> out_valid[2] pulses at each P=2, the word is not lost, and it is delivered at the first P=2 with out_ready[2]=1.
REQ-035 SHALL pass this case: N=5 with input 2 and in_dest=6 -> err_dest=1, buf_v[2] stays 0, and err_dest stays 1 until reset.
REQ-036 SHALL pass this case: en=0 with P=3 for 4 cycles -> shift_o stays 3 and buffered words deliver only if they match phase 3.
REQ-037 SHALL pass this case: rst_n asserted with 3 entries full at P=2 -> shift_o=0, out_valid=0 and in_ready=4'b1111 immediately, with no delivery after release.
